// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle-latency instruction memory,
// and presents registered instructions (with decoded field slices) to the decoder.
module instr_fetch_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic [6:0]      opcode,
    output logic [2:0]      func3,
    output logic            func7,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic            fetch_misaligned
);

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] inflight_pc;
    logic [XLEN-1:0] skid_pc;
    logic [XLEN-1:0] skid_instr;
    logic            inflight;
    logic            kill;
    logic            skid_valid;
    logic            rsp_live;

    assign imem_req  = (state_q == RUN) & ~stall & ~redirect_valid;
    assign imem_addr = pc_q;
    assign rsp_live  = inflight & ~kill;

    assign opcode = if_instr[6:0];
    assign func3  = if_instr[14:12];
    assign func7  = if_instr[30];
    assign rd     = if_instr[11:7];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= RUN;
            pc_q             <= RESET_PC;
            inflight         <= 1'b0;
            inflight_pc      <= '0;
            kill             <= 1'b0;
            skid_valid       <= 1'b0;
            skid_pc          <= '0;
            skid_instr       <= '0;
            if_valid         <= 1'b0;
            if_pc            <= '0;
            if_instr         <= NOP_INSTR;
            fetch_misaligned <= 1'b0;
        end else begin
            kill <= 1'b0;
            if (state_q == TRAP) begin
                inflight   <= 1'b0;
                skid_valid <= 1'b0;
                if_valid   <= 1'b0;
                if_instr   <= NOP_INSTR;
            end else if (redirect_valid) begin
                // Redirect wins over stall; a response arriving now is simply not captured
                inflight   <= 1'b0;
                skid_valid <= 1'b0;
                if_valid   <= 1'b0;
                if_instr   <= NOP_INSTR;
                if (redirect_pc[1:0] != 2'b00) begin
                    state_q          <= TRAP;
                    fetch_misaligned <= 1'b1;
                end else begin
                    pc_q <= redirect_pc;
                    kill <= inflight;
                end
            end else if (stall) begin
                // No request can issue while stalled, so the skid never overflows
                inflight <= 1'b0;
                if (rsp_live) begin
                    skid_valid <= 1'b1;
                    skid_instr <= imem_rdata;
                    skid_pc    <= inflight_pc;
                end
            end else begin
                pc_q        <= pc_q + XLEN'(4);
                inflight    <= 1'b1;
                inflight_pc <= pc_q;
                if (skid_valid) begin
                    skid_valid <= 1'b0;
                    if_valid   <= 1'b1;
                    if_pc      <= skid_pc;
                    if_instr   <= skid_instr;
                end else if (rsp_live) begin
                    if_valid <= 1'b1;
                    if_pc    <= inflight_pc;
                    if_instr <= imem_rdata;
                end else begin
                    if_valid <= 1'b0;
                    if_instr <= NOP_INSTR;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: queue-based fetch model checked every cycle, plus directed literals.
module tb_instr_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic        func7;
    logic [4:0]  rd, rs1, rs2;
    logic        fetch_misaligned;

    int n_checks = 0;
    int n_fails  = 0;

    instr_fetch_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .stall            (stall),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .if_valid         (if_valid),
        .if_pc            (if_pc),
        .if_instr         (if_instr),
        .opcode           (opcode),
        .func3            (func3),
        .func7            (func7),
        .rd               (rd),
        .rs1              (rs1),
        .rs2              (rs2),
        .fetch_misaligned (fetch_misaligned)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0020_81B3 : (32'hA000_0000 | (a >> 2));
    endfunction

    // Synchronous instruction memory; garbage when not requested
    always @(posedge clk) imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of requested-but-undelivered PCs; each unstalled edge delivers the oldest
    logic [31:0] m_pc        = 32'h0;
    logic [31:0] m_out_pc    = 32'h0;
    logic [31:0] m_out_instr = NOP;
    bit          m_valid     = 1'b0;
    bit          m_trap      = 1'b0;
    logic [31:0] m_q[$];

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_pc = 32'h0; m_q.delete(); m_valid = 1'b0;
                m_out_pc = 32'h0; m_out_instr = NOP; m_trap = 1'b0;
            end else if (m_trap) begin
                m_valid = 1'b0; m_out_instr = NOP;
            end else if (redirect_valid) begin
                m_valid = 1'b0; m_out_instr = NOP; m_q.delete();
                if (redirect_pc[1:0] != 2'b00) m_trap = 1'b1;
                else m_pc = redirect_pc;
            end else if (!stall) begin
                if (m_q.size() > 0) begin
                    m_out_pc    = m_q.pop_front();
                    m_out_instr = mem_word(m_out_pc);
                    m_valid     = 1'b1;
                end else begin
                    m_valid = 1'b0; m_out_instr = NOP;
                end
                m_q.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(posedge clk); #1;
            check("m_valid", 32'(if_valid), 32'(m_valid));
            check("m_misaligned", 32'(fetch_misaligned), 32'(m_trap));
            check("m_req", 32'(imem_req), 32'(!m_trap && !stall && !redirect_valid));
            if (!m_trap) check("m_addr", imem_addr, m_pc);
            if (m_valid) begin
                check("m_pc", if_pc, m_out_pc);
                check("m_instr", if_instr, m_out_instr);
                check("m_opcode", 32'(opcode), 32'(m_out_instr[6:0]));
                check("m_func3", 32'(func3), 32'(m_out_instr[14:12]));
                check("m_func7", 32'(func7), 32'(m_out_instr[30]));
                check("m_rd", 32'(rd), 32'(m_out_instr[11:7]));
                check("m_rs1", 32'(rs1), 32'(m_out_instr[19:15]));
                check("m_rs2", 32'(rs2), 32'(m_out_instr[24:20]));
            end else begin
                check("m_nop", if_instr, NOP);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic fall();
        @(negedge clk);
    endtask

    task automatic do_reset();
        fall();
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        tick(); tick();
        fall();
        rst_n = 1'b1;
    endtask

    task automatic redirect_flush(input bit with_stall);
        do_reset();
        repeat (4) tick();
        fall();
        redirect_valid = 1'b1; redirect_pc = 32'h100; stall = with_stall;
        tick();
        check("rf_valid_e5", 32'(if_valid), 32'd0);
        fall();
        redirect_valid = 1'b0; stall = 1'b0;
        tick();
        check("rf_valid_e6", 32'(if_valid), 32'd0);
        tick();
        check("rf_valid_e7", 32'(if_valid), 32'd1);
        check("rf_pc_e7", if_pc, 32'h100);
        check("rf_instr_e7", if_instr, 32'hA000_0040);
        tick();
        check("rf_pc_e8", if_pc, 32'h104);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        tick(); tick();
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_instr", if_instr, NOP);
        check("rst_misaligned", 32'(fetch_misaligned), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        fall();
        rst_n = 1'b1;

        // First fetch and streaming
        tick();
        check("e1_valid", 32'(if_valid), 32'd0);
        check("e1_addr", imem_addr, 32'h4);
        tick();
        check("e2_valid", 32'(if_valid), 32'd1);
        check("e2_pc", if_pc, 32'h0);
        check("e2_opcode", 32'(opcode), 32'h33);
        check("e2_func3", 32'(func3), 32'h0);
        check("e2_func7", 32'(func7), 32'h0);
        check("e2_rd", 32'(rd), 32'd3);
        check("e2_rs1", 32'(rs1), 32'd1);
        check("e2_rs2", 32'(rs2), 32'd2);
        check("e2_addr", imem_addr, 32'h8);
        for (int k = 3; k <= 9; k++) begin
            tick();
            check("stream_valid", 32'(if_valid), 32'd1);
            check("stream_pc", if_pc, 32'(4 * (k - 2)));
            check("stream_instr", if_instr, 32'hA000_0000 | 32'(k - 2));
        end

        // Stall with instruction at PC 8 in flight
        do_reset();
        repeat (3) tick();
        fall();
        stall = 1'b1;
        #1;
        check("stall_req", 32'(imem_req), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_pc_hold", if_pc, 32'h4);
            check("stall_valid_hold", 32'(if_valid), 32'd1);
        end
        fall();
        stall = 1'b0;
        tick();
        check("release_pc1", if_pc, 32'h8);
        check("release_instr1", if_instr, 32'hA000_0002);
        tick();
        check("release_pc2", if_pc, 32'hC);
        tick();
        check("release_pc3", if_pc, 32'h10);

        // Redirect flush, without and with a simultaneous stall
        redirect_flush(1'b0);
        redirect_flush(1'b1);

        // Misaligned redirect traps until reset
        do_reset();
        repeat (3) tick();
        fall();
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        tick();
        check("trap_flag", 32'(fetch_misaligned), 32'd1);
        check("trap_valid", 32'(if_valid), 32'd0);
        fall();
        redirect_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("trap_hold_flag", 32'(fetch_misaligned), 32'd1);
            check("trap_hold_req", 32'(imem_req), 32'd0);
            check("trap_hold_valid", 32'(if_valid), 32'd0);
        end
        do_reset();
        tick(); tick();
        check("post_trap_flag", 32'(fetch_misaligned), 32'd0);
        check("post_trap_valid", 32'(if_valid), 32'd1);
        check("post_trap_pc", if_pc, 32'h0);

        // PC wrap then asynchronous mid-stream reset
        do_reset();
        repeat (2) tick();
        fall();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        fall();
        redirect_valid = 1'b0;
        tick(); tick();
        check("wrap_pc1", if_pc, 32'hFFFF_FFFC);
        check("wrap_instr1", if_instr, 32'hBFFF_FFFF);
        tick();
        check("wrap_pc2", if_pc, 32'h0);
        check("wrap_instr2", if_instr, 32'h0020_81B3);
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(if_valid), 32'd0);
        check("async_rst_instr", if_instr, NOP);
        check("async_rst_addr", imem_addr, 32'h0);
        fall();
        rst_n = 1'b1;
        tick(); tick();
        check("restart_pc", if_pc, 32'h0);
        check("restart_valid", 32'(if_valid), 32'd1);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
